// File: rtl/ddr3_burst_ctrl.sv
// Burst sequencer between the user FIFOs and the DDR3 core command port.
// Optional macro DDR_RR_ARB_EN selects round-robin write/read arbitration.
module ddr3_burst_ctrl #(
   parameter int ADDR_W      = 28,
   parameter int LEN_W       = 8,
   parameter int CNT_W       = 11,
   parameter int RFIFO_DEPTH = 1024
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              ddr_init_done,
   input  logic [ADDR_W-1:0] app_addr_wr_min,
   input  logic [ADDR_W-1:0] app_addr_wr_max,
   input  logic [LEN_W-1:0]  wr_bust_len,
   input  logic [ADDR_W-1:0] app_addr_rd_min,
   input  logic [ADDR_W-1:0] app_addr_rd_max,
   input  logic [LEN_W-1:0]  rd_bust_len,
   input  logic              rd_enable,
   input  logic [CNT_W-1:0]  wfifo_rcount,
   input  logic [CNT_W-1:0]  rfifo_wcount,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_req,
   output logic              wfifo_rd_en,
   input  logic              rdata_valid,
   output logic              rfifo_wr_en,
   output logic              busy,
   output logic              proto_err
);

   localparam int CMP_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
   localparam int SUM_W = ADDR_W + 2;
   localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(RFIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_WR_CMD  = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_RD_CMD  = 3'd4,
      ST_RD_DATA = 3'd5,
      ST_UPD     = 3'd6
   } state_t;

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   wr_addr_r, rd_addr_r;
   logic [LEN_W-1:0]    len_q_r, beat_cnt_r;
   logic                dir_wr_r;
   logic                cmd_valid_r, cmd_wr_r, busy_r, proto_err_r;
   logic [ADDR_W-1:0]   cmd_addr_r;
   logic [LEN_W-1:0]    cmd_len_r;

   logic                wr_go_s, rd_go_s, pick_rd_s;
   logic                start_wr_s, start_rd_s, beat_s, last_s, stray_s;
   logic [LEN_W-1:0]    start_len_s;
   logic [ADDR_W-1:0]   upd_base_s, upd_min_s, upd_max_s, upd_addr_s;
   logic [SUM_W-1:0]    step_s, next_s;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len == {LEN_W{1'b0}}) ? LEN_W'(1) : len;
   endfunction

   assign wr_go_s = CMP_W'(wfifo_rcount) >= CMP_W'(wr_bust_len);
   assign rd_go_s = rd_enable && (CMP_W'(rfifo_wcount) <= DEPTH_C) &&
                    ((DEPTH_C - CMP_W'(rfifo_wcount)) >= CMP_W'(rd_bust_len));

`ifdef DDR_RR_ARB_EN
   // Last direction served loses a tie.
   assign pick_rd_s = dir_wr_r;
`else
   assign pick_rd_s = 1'b0;
`endif

   assign beat_s  = ((state_r == ST_WR_DATA) && wdata_req) ||
                    ((state_r == ST_RD_DATA) && rdata_valid);
   assign last_s  = (beat_cnt_r == (len_q_r - LEN_W'(1)));
   assign stray_s = (wdata_req && (state_r != ST_WR_DATA)) ||
                    (rdata_valid && (state_r != ST_RD_DATA));

   // Next-state and arbitration decode.
   always_comb begin
      state_s     = state_r;
      start_wr_s  = 1'b0;
      start_rd_s  = 1'b0;
      start_len_s = clamp_len(wr_bust_len);
      if (!ddr_init_done) begin
         state_s = ST_INIT;
      end else begin
         case (state_r)
            ST_INIT: state_s = ST_IDLE;
            ST_IDLE: begin
               if (wr_go_s && !(rd_go_s && pick_rd_s)) begin
                  state_s    = ST_WR_CMD;
                  start_wr_s = 1'b1;
               end else if (rd_go_s) begin
                  state_s     = ST_RD_CMD;
                  start_rd_s  = 1'b1;
                  start_len_s = clamp_len(rd_bust_len);
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_WR_CMD: begin
               if (cmd_ready) state_s = ST_WR_DATA;
               else           state_s = ST_WR_CMD;
            end
            ST_RD_CMD: begin
               if (cmd_ready) state_s = ST_RD_DATA;
               else           state_s = ST_RD_CMD;
            end
            ST_WR_DATA, ST_RD_DATA: begin
               if (beat_s && last_s) state_s = ST_UPD;
               else                  state_s = state_r;
            end
            ST_UPD:  state_s = ST_IDLE;
            default: state_s = ST_INIT;
         endcase
      end
   end

   // Address advance: wrap to min when the following burst would not fit.
   always_comb begin
      upd_base_s = dir_wr_r ? wr_addr_r : rd_addr_r;
      upd_min_s  = dir_wr_r ? app_addr_wr_min : app_addr_rd_min;
      upd_max_s  = dir_wr_r ? app_addr_wr_max : app_addr_rd_max;
      step_s     = SUM_W'({len_q_r, 3'b000});
      next_s     = SUM_W'(upd_base_s) + step_s;
      if (((next_s + step_s) > SUM_W'(upd_max_s)) || (next_s < SUM_W'(upd_min_s))) begin
         upd_addr_s = upd_min_s;
      end else begin
         upd_addr_s = next_s[ADDR_W-1:0];
      end
   end

   // State, address, counter and registered output updates.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r     <= ST_INIT;
         wr_addr_r   <= {ADDR_W{1'b0}};
         rd_addr_r   <= {ADDR_W{1'b0}};
         len_q_r     <= {LEN_W{1'b0}};
         beat_cnt_r  <= {LEN_W{1'b0}};
         dir_wr_r    <= 1'b0;
         cmd_valid_r <= 1'b0;
         cmd_wr_r    <= 1'b0;
         cmd_addr_r  <= {ADDR_W{1'b0}};
         cmd_len_r   <= {LEN_W{1'b0}};
         busy_r      <= 1'b0;
         proto_err_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cmd_valid_r <= (state_s == ST_WR_CMD) || (state_s == ST_RD_CMD);
         busy_r      <= (state_s != ST_INIT) && (state_s != ST_IDLE);
         proto_err_r <= proto_err_r | stray_s;

         if ((state_s == ST_WR_DATA) || (state_s == ST_RD_DATA)) begin
            beat_cnt_r <= beat_cnt_r + (beat_s ? LEN_W'(1) : LEN_W'(0));
         end else begin
            beat_cnt_r <= {LEN_W{1'b0}};
         end

         if (start_wr_s || start_rd_s) begin
            len_q_r    <= start_len_s;
            dir_wr_r   <= start_wr_s;
            cmd_wr_r   <= start_wr_s;
            cmd_addr_r <= start_wr_s ? wr_addr_r : rd_addr_r;
            cmd_len_r  <= start_len_s;
         end else begin
            len_q_r    <= len_q_r;
            dir_wr_r   <= dir_wr_r;
            cmd_wr_r   <= cmd_wr_r;
            cmd_addr_r <= cmd_addr_r;
            cmd_len_r  <= cmd_len_r;
         end

         if ((state_r == ST_INIT) && (state_s == ST_IDLE)) begin
            wr_addr_r <= app_addr_wr_min;
            rd_addr_r <= app_addr_rd_min;
         end else if ((state_r == ST_UPD) && (state_s == ST_IDLE)) begin
            if (dir_wr_r) wr_addr_r <= upd_addr_s;
            else          rd_addr_r <= upd_addr_s;
         end else begin
            wr_addr_r <= wr_addr_r;
            rd_addr_r <= rd_addr_r;
         end
      end
   end

   assign cmd_valid   = cmd_valid_r;
   assign cmd_wr      = cmd_wr_r;
   assign cmd_addr    = cmd_addr_r;
   assign cmd_len     = cmd_len_r;
   assign busy        = busy_r;
   assign proto_err   = proto_err_r;
   assign wfifo_rd_en = (state_r == ST_WR_DATA) && wdata_req;
   assign rfifo_wr_en = (state_r == ST_RD_DATA) && rdata_valid;

endmodule

// File: tb/tb_ddr3_burst_ctrl.sv
// Directed bench for ddr3_burst_ctrl: init hold, handshake, address walk,
// read gating, arbitration, stray-beat error, abort and async reset.
module tb_ddr3_burst_ctrl;

   localparam int ADDR_W = 28;
   localparam int LEN_W  = 8;
   localparam int CNT_W  = 11;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ddr_init_done;
   logic [ADDR_W-1:0] wr_min, wr_max, rd_min, rd_max;
   logic [LEN_W-1:0]  wr_len, rd_len;
   logic              rd_enable;
   logic [CNT_W-1:0]  wfifo_rcount, rfifo_wcount;
   logic              cmd_valid, cmd_ready, cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wdata_req, wfifo_rd_en, rdata_valid, rfifo_wr_en;
   logic              busy, proto_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ddr3_burst_ctrl dut (
      .sys_clk        (clk),
      .sys_rst_n      (rst_n),
      .ddr_init_done  (ddr_init_done),
      .app_addr_wr_min(wr_min),
      .app_addr_wr_max(wr_max),
      .wr_bust_len    (wr_len),
      .app_addr_rd_min(rd_min),
      .app_addr_rd_max(rd_max),
      .rd_bust_len    (rd_len),
      .rd_enable      (rd_enable),
      .wfifo_rcount   (wfifo_rcount),
      .rfifo_wcount   (rfifo_wcount),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_wr         (cmd_wr),
      .cmd_addr       (cmd_addr),
      .cmd_len        (cmd_len),
      .wdata_req      (wdata_req),
      .wfifo_rd_en    (wfifo_rd_en),
      .rdata_valid    (rdata_valid),
      .rfifo_wr_en    (rfifo_wr_en),
      .busy           (busy),
      .proto_err      (proto_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge where cmd_valid is seen.
   task automatic wait_cmd(input string tag);
      int n = 0;
      while (cmd_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(n < 200), 64'd1);
   endtask

   // Called on the negedge after the handshake; ends on the negedge in UPD.
   task automatic run_wr_burst(input int n, input string tag);
      int pulses = 0;
      for (int i = 0; i < n; i++) begin
         wdata_req = 1'b1;
         #1 pulses += int'(wfifo_rd_en);
         @(negedge clk);
      end
      wdata_req = 1'b0;
      check(tag, 64'(pulses), 64'(n));
   endtask

   // Gapped read beats: valid on every second cycle, 64 beats total.
   task automatic run_rd_burst(input string tag);
      int pushes = 0;
      int bad = 0;
      for (int i = 0; i < 128; i++) begin
         rdata_valid = (i % 2) == 1;
         #1;
         if (rfifo_wr_en !== rdata_valid) bad++;
         pushes += int'(rfifo_wr_en);
         @(negedge clk);
      end
      rdata_valid = 1'b0;
      check({tag, "_mirror"}, 64'(bad), 64'd0);
      check({tag, "_count"}, 64'(pushes), 64'd64);
   endtask

   initial begin
      logic [63:0] snap;
      int bad;

      rst_n = 1'b0;  ddr_init_done = 1'b0;
      wr_min = 28'd0;       wr_max = 28'd5120;    wr_len = 8'd64;
      rd_min = 28'h10000;   rd_max = 28'h12000;   rd_len = 8'd64;
      rd_enable = 1'b0;  wfifo_rcount = 11'd100;  rfifo_wcount = 11'd0;
      cmd_ready = 1'b0;  wdata_req = 1'b0;  rdata_valid = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_proto_err", 64'(proto_err), 64'd0);
      check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
      rst_n = 1'b1;

      // Calibration not done: nothing may be issued.
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (cmd_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("init_hold", 64'(bad), 64'd0);

      ddr_init_done = 1'b1;
      @(negedge clk);
      check("first_cmd_early", 64'(cmd_valid), 64'd0);
      @(negedge clk);
      check("first_cmd_valid", 64'(cmd_valid), 64'd1);
      check("first_cmd_wr", 64'(cmd_wr), 64'd1);
      check("first_cmd_addr", 64'(cmd_addr), 64'd0);
      check("first_cmd_len", 64'(cmd_len), 64'd64);
      check("first_busy", 64'(busy), 64'd1);

      // cmd_ready low for 7 cycles: command must hold.
      snap = {25'd0, cmd_valid, cmd_wr, cmd_addr, cmd_len};
      bad = 0;
      repeat (7) begin
         @(negedge clk);
         if ({25'd0, cmd_valid, cmd_wr, cmd_addr, cmd_len} !== snap) bad++;
      end
      check("cmd_hold_stable", 64'(bad), 64'd0);
      cmd_ready = 1'b1;
      wfifo_rcount = 11'd64;
      @(negedge clk);
      check("cmd_drop_after_hs", 64'(cmd_valid), 64'd0);
      run_wr_burst(64, "wr_pulses_0");
      check("upd_busy", 64'(busy), 64'd1);

      // Address walk 512 .. 4608 then wrap to 0.
      for (int i = 1; i <= 10; i++) begin
         wait_cmd("walk_wait");
         check($sformatf("walk_addr_%0d", i), 64'(cmd_addr), 64'((i % 10) * 512));
         check($sformatf("walk_wr_%0d", i), 64'(cmd_wr), 64'd1);
         @(negedge clk);
         check($sformatf("walk_one_cmd_%0d", i), 64'(cmd_valid), 64'd0);
         run_wr_burst(64, $sformatf("walk_pulses_%0d", i));
      end
      wfifo_rcount = 11'd0;

      // Read gating: 54 free slots < 64.
      rd_enable = 1'b1;
      rfifo_wcount = 11'd970;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (cmd_valid !== 1'b0) bad++;
      end
      check("rd_gated", 64'(bad), 64'd0);
      rfifo_wcount = 11'd960;
      wait_cmd("rd_wait");
      check("rd_cmd_wr", 64'(cmd_wr), 64'd0);
      check("rd_cmd_addr", 64'(cmd_addr), 64'h10000);
      check("rd_cmd_len", 64'(cmd_len), 64'd64);
      @(negedge clk);
      run_rd_burst("rd_gap");
      rd_enable = 1'b0;

      // Arbitration: both directions ready, write wins the first contest.
      wfifo_rcount = 11'd64;
      rd_enable = 1'b1;
      rfifo_wcount = 11'd0;
      @(negedge clk);
      wait_cmd("arb1_wait");
      check("arb1_wr", 64'(cmd_wr), 64'd1);
      check("arb1_addr", 64'(cmd_addr), 64'd512);
      @(negedge clk);
      run_wr_burst(64, "arb1_pulses");
      wait_cmd("arb2_wait");
`ifdef DDR_RR_ARB_EN
      check("arb2_wr", 64'(cmd_wr), 64'd0);
      check("arb2_addr", 64'(cmd_addr), 64'h10200);
      wfifo_rcount = 11'd0;
      rd_enable = 1'b0;
      @(negedge clk);
      run_rd_burst("arb2_rd");
`else
      check("arb2_wr", 64'(cmd_wr), 64'd1);
      check("arb2_addr", 64'(cmd_addr), 64'd1024);
      wfifo_rcount = 11'd0;
      rd_enable = 1'b0;
      @(negedge clk);
      run_wr_burst(64, "arb2_pulses");
`endif
      @(negedge clk);
      @(negedge clk);

      // Stray read beat in IDLE.
      check("err_clear_before", 64'(proto_err), 64'd0);
      rdata_valid = 1'b1;
      #1 check("err_no_push", 64'(rfifo_wr_en), 64'd0);
      @(negedge clk);
      rdata_valid = 1'b0;
      check("err_sticky", 64'(proto_err), 64'd1);
      repeat (3) @(negedge clk);
      check("err_held", 64'(proto_err), 64'd1);

      // Abort after 10 of 64 write beats.
      wr_min = 28'd2560;
      wfifo_rcount = 11'd64;
      wait_cmd("abort_wait");
      check("abort_cmd_wr", 64'(cmd_wr), 64'd1);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         wdata_req = 1'b1;
         #1 if (wfifo_rd_en !== 1'b1) bad++;
         @(negedge clk);
      end
      check("abort_beats", 64'(bad), 64'd0);
      ddr_init_done = 1'b0;
      @(negedge clk);
      check("abort_strobe", 64'(wfifo_rd_en), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_cmd_valid", 64'(cmd_valid), 64'd0);
      wdata_req = 1'b0;
      @(negedge clk);
      ddr_init_done = 1'b1;
      wait_cmd("reinit_wait");
      check("reinit_addr", 64'(cmd_addr), 64'd2560);
      check("reinit_wr", 64'(cmd_wr), 64'd1);

      // Asynchronous reset while a command is pending.
      cmd_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_proto_err", 64'(proto_err), 64'd0);
      check("arst_cmd_addr", 64'(cmd_addr), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ddr3_burst_ctrl.md
Name: ddr3_burst_ctrl

Overview:
- Memory-side counterpart of the user traffic interface of the DDR3 controller wrapper.
- Watches the write-FIFO fill level and read-FIFO free space, then issues write and read burst commands to the DDR3 core's command port.
- Paces FIFO pops and pushes per data beat, and walks write and read addresses between programmable min and max bounds with wrap-around.
- Addresses are in 16-bit units; one data beat is 128 bits, so one beat equals 8 address units.

Parameters:
ADDR_W, 28, address width (16-bit units)
LEN_W, 8, burst length width (128-bit beats)
CNT_W, 11, FIFO count width
RFIFO_DEPTH, 1024, read FIFO depth in beats

Ports:
sys_clk  in  1  single clock for all logic
sys_rst_n  in  1  asynchronous active-low reset
ddr_init_done  in  1  DDR3 calibration complete
app_addr_wr_min  in  ADDR_W  write region start
app_addr_wr_max  in  ADDR_W  write region end (exclusive)
wr_bust_len  in  LEN_W  write burst length in beats
app_addr_rd_min  in  ADDR_W  read region start
app_addr_rd_max  in  ADDR_W  read region end (exclusive)
rd_bust_len  in  LEN_W  read burst length in beats
rd_enable  in  1  reads permitted
wfifo_rcount  in  CNT_W  beats available in write FIFO
rfifo_wcount  in  CNT_W  beats stored in read FIFO
cmd_valid  out  1  command request
cmd_ready  in  1  core accepts command
cmd_wr  out  1  1 = write burst, 0 = read burst
cmd_addr  out  ADDR_W  burst start address
cmd_len  out  LEN_W  burst length in beats
wdata_req  in  1  core consumes one write beat this cycle
wfifo_rd_en  out  1  pop write FIFO
rdata_valid  in  1  core presents one read beat this cycle
rfifo_wr_en  out  1  push read FIFO
busy  out  1  burst in progress
proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset: every registered output is 0. wr_addr = 0, rd_addr = 0, beat counter = 0, state = INIT.
- Clock and reset: single clock. sys_rst_n is asynchronous active-low.
- INIT: wait for ddr_init_done = 1. On that cycle, load wr_addr = app_addr_wr_min and rd_addr = app_addr_rd_min, then go to IDLE.
- IDLE arbitration, evaluated every cycle:
  - write condition: wfifo_rcount >= wr_bust_len, go to WR_CMD;
  - read condition: rd_enable = 1 and (RFIFO_DEPTH - rfifo_wcount) >= rd_bust_len, go to RD_CMD;
  - if both conditions hold, write wins;
  - the length is latched into len_q on the transition. A length of 0 is clamped to 1.
- WR_CMD / RD_CMD:
  - cmd_valid = 1, cmd_wr = 1 for write / 0 for read, cmd_addr = wr_addr or rd_addr, cmd_len = len_q;
  - all command outputs hold stable until cmd_ready = 1;
  - the handshake completes on the cycle where cmd_valid and cmd_ready are both 1. cmd_valid drops the next cycle, and state moves to WR_DATA or RD_DATA.
- WR_DATA:
  - wfifo_rd_en = wdata_req, combinational, zero latency;
  - the beat counter increments on each wdata_req;
  - when wdata_req = 1 and count = len_q - 1, go to UPD.
- RD_DATA:
  - rfifo_wr_en = rdata_valid, combinational;
  - the beat counter increments on each rdata_valid;
  - last beat goes to UPD.
- UPD (1 cycle):
  - next = addr + len_q*8, computed in ADDR_W+1 bits with no overflow;
  - if next + len_q*8 > max, or next < min, addr = min; otherwise addr = next;
  - clear the counter and return to IDLE;
  - min/max are sampled here, so changes made mid-burst take effect at the next update.
- Example: min = 0, max = 5120, len = 64 gives bursts at 0, 512, …, 4608, then the address wraps to 0 (10 bursts per pass).
- busy = 1 in WR_CMD, WR_DATA, RD_CMD, RD_DATA and UPD.
- proto_err is set, and held until reset, in two cases:
  - wdata_req is seen outside WR_DATA;
  - rdata_valid is seen outside RD_DATA.
  Stray beats are ignored: no FIFO strobe is generated.
- ddr_init_done falling in any state other than INIT:
  - the current burst is abandoned and state goes to INIT;
  - cmd_valid and the FIFO strobes go to 0 the next cycle;
  - addresses reload from min when calibration completes again.
- Asynchronous reset mid-burst returns the block to its reset values immediately.

Optional Feature:
- Macro: DDR_RR_ARB_EN.
- Defined: IDLE arbitration is round-robin. When both requests are pending, the direction not served last wins. A last_wr flag is reset to 0, so the first contest goes to write.
- Undefined: fixed write priority as described in Behaviour.

Test Plan:
- Idle hold: ddr_init_done = 0 for 50 cycles, wfifo_rcount = 100 -> cmd_valid stays 0 and busy stays 0. After ddr_init_done rises, first cmd_valid appears 2 cycles later with cmd_wr = 1, cmd_addr = 0, cmd_len = 64.
- Write address walk: min = 0, max = 5120, len = 64, wfifo_rcount held at 64, cmd_ready = 1 -> cmd_addr sequence 0, 512, …, 4608, 0. Exactly 64 wfifo_rd_en pulses per burst.
- Command handshake: cmd_ready held low for 7 cycles -> cmd_valid, cmd_addr and cmd_len stay stable. Exactly one command per burst.
- Arbitration: both write and read conditions true -> write issued first. With DDR_RR_ARB_EN defined, the next contest goes to read.
- Read gating: rfifo_wcount = 970, RFIFO_DEPTH = 1024, rd_bust_len = 64 -> no read command. At rfifo_wcount = 960 -> read at rd_addr. rfifo_wr_en mirrors rdata_valid, including gapped beats.
- Error and abort: rdata_valid pulsed in IDLE -> proto_err = 1, no rfifo_wr_en. ddr_init_done dropped after 10 of 64 write beats -> INIT, strobes 0, next burst starts at app_addr_wr_min.
